// File: rtl/reference_index_gen.sv
// Issues indices into a circular I/Q reference buffer using a valid/ready handshake.
// A run is one or more passes of sweep_len indices, each pass starting again at start_index.
module reference_index_gen #(
  parameter int unsigned buffer_length = 10,
  parameter int unsigned index_bits    = 4,
  parameter int unsigned pass_bits     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [index_bits-1:0] start_index,
  input  logic [index_bits:0]   sweep_len,
  input  logic [pass_bits-1:0]  num_passes,
  input  logic                  abort,
  input  logic                  s_axi_data_rready,
  output logic                  m_axi_rvalid,
  output logic [index_bits-1:0] m_axi_index_rdata,
  output logic                  busy,
  output logic                  pass_done,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  localparam logic [index_bits:0]   BufLen  = (index_bits + 1)'(buffer_length);
  localparam logic [index_bits-1:0] LastIdx = index_bits'(buffer_length - 1);

  state_e                state;
  logic [index_bits-1:0] cfg_start;
  logic [index_bits:0]   cfg_len;
  logic [pass_bits-1:0]  cfg_passes;
  logic [index_bits:0]   xfer_cnt;
  logic [pass_bits-1:0]  pass_cnt;

  logic xfer, last_xfer, last_pass, start_ok;

  assign xfer      = m_axi_rvalid & s_axi_data_rready;
  assign last_xfer = (xfer_cnt == cfg_len - (index_bits + 1)'(1));
  // A zero pass count never matches, so the sweep runs until abort.
  assign last_pass = (cfg_passes != '0) && (pass_cnt == cfg_passes - pass_bits'(1));
  assign start_ok  = ({1'b0, start_index} < BufLen) && (sweep_len <= BufLen);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= StIdle;
      m_axi_rvalid      <= 1'b0;
      m_axi_index_rdata <= '0;
      busy              <= 1'b0;
      pass_done         <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      cfg_start         <= '0;
      cfg_len           <= '0;
      cfg_passes        <= '0;
      xfer_cnt          <= '0;
      pass_cnt          <= '0;
    end else begin
      pass_done <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            if (start_ok) begin
              state             <= StRun;
              busy              <= 1'b1;
              m_axi_rvalid      <= 1'b1;
              m_axi_index_rdata <= start_index;
              cfg_start         <= start_index;
              cfg_len           <= (sweep_len == '0) ? BufLen : sweep_len;
              cfg_passes        <= num_passes;
              xfer_cnt          <= '0;
              pass_cnt          <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        StRun: begin
          // Abort wins over any pass or final completion in the same cycle.
          if (abort) begin
            state        <= StIdle;
            busy         <= 1'b0;
            m_axi_rvalid <= 1'b0;
          end else if (xfer) begin
            if (last_xfer) begin
              xfer_cnt          <= '0;
              pass_done         <= 1'b1;
              m_axi_index_rdata <= cfg_start;
              if (last_pass) begin
                state        <= StFinish;
                m_axi_rvalid <= 1'b0;
                done         <= 1'b1;
              end else begin
                pass_cnt <= pass_cnt + pass_bits'(1);
              end
            end else begin
              xfer_cnt          <= xfer_cnt + (index_bits + 1)'(1);
              m_axi_index_rdata <= (m_axi_index_rdata == LastIdx) ? '0
                                 : m_axi_index_rdata + index_bits'(1);
            end
          end
        end
        StFinish: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reference_index_gen.sv
// Randomized bench for reference_index_gen; expected indices and pulses come from
// plain arithmetic over the transfer count, not from a copy of the state machine.
module tb_reference_index_gen;

  localparam int BL = 10;
  localparam int IB = 4;
  localparam int PB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [IB-1:0] start_index = '0;
  logic [IB:0]   sweep_len = '0;
  logic [PB-1:0] num_passes = '0;
  logic          abort = 1'b0;
  logic          ready = 1'b0;
  logic          m_axi_rvalid;
  logic [IB-1:0] m_axi_index_rdata;
  logic          busy, pass_done, done, err;

  int n_checks = 0;
  int n_pass = 0;

  reference_index_gen #(
    .buffer_length(BL),
    .index_bits   (IB),
    .pass_bits    (PB)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .start_index      (start_index),
    .sweep_len        (sweep_len),
    .num_passes       (num_passes),
    .abort            (abort),
    .s_axi_data_rready(ready),
    .m_axi_rvalid     (m_axi_rvalid),
    .m_axi_index_rdata(m_axi_index_rdata),
    .busy             (busy),
    .pass_done        (pass_done),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Index of the n-th transfer (0-based) of a sweep.
  function automatic int exp_idx(input int si, input int len, input int n);
    return (si + (n % len)) % BL;
  endfunction

  // Called at a negedge; drives start immediately so back-to-back runs test restart.
  task automatic run_sweep(input int si, input int len_in, input int np, input int pct,
                           input int abort_at);
    int len = (len_in == 0) ? BL : len_in;
    int n = 0;
    bit pd = 0, dn = 0, ended = 0;
    start = 1'b1;
    start_index = IB'(si);
    sweep_len = (IB + 1)'(len_in);
    num_passes = PB'(np);
    for (int cyc = 0; cyc < 3000 && !ended; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("pass_done", pass_done, pd);
      check("done", done, dn);
      check("valid", m_axi_rvalid, 1);
      check("busy", busy, 1);
      check("index", m_axi_index_rdata, exp_idx(si, len, n));
      pd = 0;
      dn = 0;
      ready = ($urandom_range(99) < pct);
      if (abort_at != 0 && n + 1 == abort_at) begin
        ready = 1'b1;
        abort = 1'b1;
      end
      if (ready) begin
        n++;
        pd = (n % len == 0);
        dn = pd && np != 0 && n == len * np;
        if (abort) begin
          pd = 0;
          dn = 0;
          ended = 1;
        end else if (dn) begin
          ended = 1;
        end
      end
    end
    if (!ended) check("timeout", 0, 1);
    @(negedge clk);
    abort = 1'b0;
    ready = 1'b0;
    check("end_valid", m_axi_rvalid, 0);
    check("end_pass_done", pass_done, pd);
    check("end_done", done, dn);
    check("end_busy", busy, dn);
    if (dn) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
    end
  endtask

  task automatic err_case(input int si, input int len_in);
    bit exp_err = (si >= BL) || (len_in > BL);
    start = 1'b1;
    start_index = IB'(si);
    sweep_len = (IB + 1)'(len_in);
    num_passes = 8'd1;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", err, exp_err);
    check("err_busy", busy, 0);
    check("err_valid", m_axi_rvalid, 0);
    @(negedge clk);
    check("err_clear", err, 0);
    check("err_idle", busy, 0);
  endtask

  initial begin
    #1;
    check("rst_valid", m_axi_rvalid, 0);
    check("rst_index", m_axi_index_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {pass_done, done, err}, 0);
    #11 rst_n = 1'b1;
    @(negedge clk);

    run_sweep(0, 10, 1, 100, 0);
    run_sweep(7, 5, 1, 100, 0);
    run_sweep(2, 4, 1, 40, 0);
    run_sweep(3, 2, 2, 100, 0);
    run_sweep(3, 2, 2, 100, 4);
    run_sweep(5, 0, 0, 70, 3);
    run_sweep(1, 3, 0, 100, 23);
    @(negedge clk);
    err_case(12, 4);
    err_case(0, 11);
    err_case(15, 16);

    for (int i = 0; i < 8; i++) begin
      run_sweep($urandom_range(BL - 1), $urandom_range(BL), $urandom_range(3, 1),
                $urandom_range(100, 30), 0);
    end
    run_sweep($urandom_range(BL - 1), $urandom_range(BL), 0, 60, $urandom_range(30, 1));

    // Asynchronous reset between clock edges in the middle of a continuous sweep.
    @(negedge clk);
    ready = 1'b1;
    start = 1'b1;
    start_index = 4'd6;
    sweep_len = '0;
    num_passes = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", m_axi_rvalid, 0);
    check("async_busy", busy, 0);
    check("async_index", m_axi_index_rdata, 0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    run_sweep(4, 3, 1, 100, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
